icache_refill_ctrl: RTL and testbench

- Sequencing controller for the instruction-cache data array in the fetch path.
- Accepts 128-bit line fetch requests from the IFQ and looks them up in an internal direct-mapped tag/valid array.
- On a hit, returns the line from the external data array.
- On a miss, runs a 4-beat 32-bit refill from the memory port, writes the line into the data array and returns it.
- Handles branch aborts and full invalidation.

---
 rtl/icache_refill_ctrl_pkg.sv | 29 ++
 rtl/icache_tag_array.sv | 51 +++++
 rtl/icache_refill_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// ============================================================================
// icache_refill_ctrl_pkg : shared widths and FSM encoding for the I-cache
// refill controller.  Rev 1.0
// ============================================================================
`default_nettype none

package icache_refill_ctrl_pkg;

    localparam int ICACHE_LINE_W = 128;
    localparam int ICACHE_BEAT_W = 32;
    localparam int ICACHE_OFF_W  = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_MISS_REQ = 3'd2;
    localparam logic [2:0] ST_REFILL   = 3'd3;
    localparam logic [2:0] ST_FILL     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        LOOKUP   = ST_LOOKUP,
        MISS_REQ = ST_MISS_REQ,
        REFILL   = ST_REFILL,
        FILL     = ST_FILL
    } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_tag_array.sv
// ============================================================================
// icache_tag_array : direct-mapped tag/valid store, combinational read,
// single write port and single-cycle bulk invalidate.  Rev 1.0
// ============================================================================
`default_nettype none

module icache_tag_array
    import icache_refill_ctrl_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - ICACHE_OFF_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_valid_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             inv_all_i
);

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;

    // Bulk invalidate wins over a same-cycle write so a line filled while an
    // invalidate is pending never becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// icache_refill_ctrl : I-cache lookup and 4-beat line refill sequencer with
// branch abort and full invalidation.  Rev 1.0
// ============================================================================
`default_nettype none

module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int BEATS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en_i,
    input  logic [31:0]              pc_in_i,
    input  logic                     abort_i,
    input  logic                     inv_i,
    output logic                     ready_o,
    output logic [ICACHE_LINE_W-1:0] dout_o,
    output logic                     dout_valid_o,
    output logic                     data_rd_en_o,
    output logic [IDX_W-1:0]         data_idx_o,
    input  logic [ICACHE_LINE_W-1:0] data_rdata_i,
    output logic                     data_we_o,
    output logic [ICACHE_LINE_W-1:0] data_wdata_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [ICACHE_BEAT_W-1:0] mem_rdata_i
);

    localparam int TAG_W = 32 - ICACHE_OFF_W - IDX_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    icache_state_e            state_q, state_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                     abort_pend_q, abort_pend_d;
    logic                     inv_pend_q, inv_pend_d;
    logic [ICACHE_LINE_W-1:0] linebuf_q, linebuf_d;

    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [TAG_W-1:0] arr_tag;
    logic             arr_valid;
    logic             hit;
    logic             inv_apply;
    logic             unused_pc_bits;

    assign pc_idx         = pc_in_i[ICACHE_OFF_W +: IDX_W];
    assign pc_tag         = pc_in_i[31 : ICACHE_OFF_W + IDX_W];
    assign unused_pc_bits = ^pc_in_i[ICACHE_OFF_W-1:0];

    icache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (idx_q),
        .rd_tag_o   (arr_tag),
        .rd_valid_o (arr_valid),
        .we_i       (state_q == FILL),
        .wr_idx_i   (idx_q),
        .wr_tag_i   (tag_q),
        .inv_all_i  (inv_apply)
    );

    assign hit = arr_valid && (arr_tag == tag_q);

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        beat_cnt_d   = beat_cnt_q;
        abort_pend_d = abort_pend_q;
        linebuf_d    = linebuf_q;
        ready_o      = 1'b0;
        dout_o       = '0;
        dout_valid_o = 1'b0;
        data_rd_en_o = 1'b0;
        data_idx_o   = '0;
        data_we_o    = 1'b0;
        data_wdata_o = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            LOOKUP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (hit) begin
                    ready_o      = 1'b1;
                    dout_o       = data_rdata_i;
                    dout_valid_o = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag_q, idx_q, {ICACHE_OFF_W{1'b0}}};
                if (mem_gnt_i) begin
                    state_d    = REFILL;
                    beat_cnt_d = '0;
                    if (abort_i) begin
                        abort_pend_d = 1'b1;
                    end
                end else if (abort_i) begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                // Memory cannot cancel a granted burst, so beats drain even
                // after an abort; only the final return is suppressed.
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    linebuf_d[ICACHE_BEAT_W*beat_cnt_q +: ICACHE_BEAT_W] = mem_rdata_i;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS-1)) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                data_we_o    = 1'b1;
                data_idx_o   = idx_q;
                data_wdata_o = linebuf_q;
                dout_o       = linebuf_q;
                dout_valid_o = !abort_pend_q && !abort_i;
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ready_o && rd_en_i) begin
            data_rd_en_o = 1'b1;
            data_idx_o   = pc_idx;
            tag_d        = pc_tag;
            idx_d        = pc_idx;
            state_d      = LOOKUP;
        end
    end

    // Invalidate takes effect immediately in IDLE, otherwise on the cycle the
    // FSM drops back to IDLE (including the FILL cycle, killing the new line).
    assign inv_apply  = ((state_q == IDLE) && inv_i) ||
                        ((state_q != IDLE) && (state_d == IDLE) && (inv_pend_q || inv_i));
    assign inv_pend_d = inv_apply ? 1'b0 : (inv_pend_q || inv_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            idx_q        <= '0;
            beat_cnt_q   <= '0;
            abort_pend_q <= 1'b0;
            inv_pend_q   <= 1'b0;
            linebuf_q    <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            beat_cnt_q   <= beat_cnt_d;
            abort_pend_q <= abort_pend_d;
            inv_pend_q   <= inv_pend_d;
            linebuf_q    <= linebuf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// tb_icache_refill_ctrl : vector table, directed corner sequences and random
// transactions against a line-level cache model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill_ctrl;

    localparam int LINES = 64;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rd_en, abort, inv, mem_gnt, mem_rvalid;
    logic [31:0]      pc, mem_rdata;
    logic             ready, dout_valid, data_rd_en, data_we, mem_req;
    logic [127:0]     dout, data_wdata;
    logic [127:0]     data_rdata = '0;
    logic [IDX_W-1:0] data_idx;
    logic [31:0]      mem_addr;

    int n_vec = 0;
    int n_err = 0;

    // environment: external data array, and the line-level cache model
    logic [127:0]     darr [LINES];
    bit               mvalid [LINES];
    logic [TAG_W-1:0] mtag [LINES];

    always #5 clk = ~clk;

    icache_refill_ctrl #(.LINES(LINES), .IDX_W(IDX_W), .BEATS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en_i      (rd_en),
        .pc_in_i      (pc),
        .abort_i      (abort),
        .inv_i        (inv),
        .ready_o      (ready),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .data_rd_en_o (data_rd_en),
        .data_idx_o   (data_idx),
        .data_rdata_i (data_rdata),
        .data_we_o    (data_we),
        .data_wdata_o (data_wdata),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    always @(posedge clk) begin
        if (data_rd_en) data_rdata <= darr[data_idx];
        if (data_we)    darr[data_idx] <= data_wdata;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit               rd;
        logic [31:0]      pc;
        bit               gnt;
        bit               rv;
        logic [31:0]      rdat;
        bit               e_rdy;
        bit               e_dv;
        bit               e_req;
        logic [31:0]      e_addr;
        bit               e_we;
        bit               e_rden;
        logic [IDX_W-1:0] e_idx;
        logic [127:0]     e_dout;
    } vec_t;

    function automatic vec_t mkv(bit rd, logic [31:0] p, bit g, bit rv, logic [31:0] rdat,
                                 bit rdy, bit dv, bit req, logic [31:0] addr, bit we,
                                 bit rden, logic [IDX_W-1:0] ix, logic [127:0] d);
        vec_t v;
        v.rd = rd; v.pc = p; v.gnt = g; v.rv = rv; v.rdat = rdat;
        v.e_rdy = rdy; v.e_dv = dv; v.e_req = req; v.e_addr = addr; v.e_we = we;
        v.e_rden = rden; v.e_idx = ix; v.e_dout = d;
        return v;
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] a, input int b);
        return {a[31:4], 4'h0} ^ (32'h1357_9BDF * 32'(b + 1));
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {memw(a, 3), memw(a, 2), memw(a, 1), memw(a, 0)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        rd_en = 0; abort = 0; inv = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic model_inv();
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    endtask

    // amode: 0 none, 1 abort in lookup, 2 abort before grant, 3 abort on beat k,
    //        4 abort with grant, 5 abort in fill cycle
    task automatic txn(input logic [31:0] a, input int amode, input int k,
                       input bit do_inv, output bit obs_hit);
        int               ix;
        logic [TAG_W-1:0] tg;
        bit               phit, pdv;
        logic [127:0]     line;
        int               w;
        ix   = int'(a[4 +: IDX_W]);
        tg   = a[31:4+IDX_W];
        phit = mvalid[ix] && (mtag[ix] == tg);
        line = line_of(a);
        obs_hit = 0;

        @(negedge clk); clr(); rd_en = 1; pc = a; #1;
        chk("acc_ready", ready, 1);
        chk("acc_rden", data_rd_en, 1);
        chk("acc_idx", data_idx, ix);

        @(negedge clk); clr(); abort = (amode == 1); #1;
        obs_hit = dout_valid;
        chk("lk_dv", dout_valid, phit && amode != 1);
        chk("lk_ready", ready, phit && amode != 1);
        if (phit && amode != 1) chk("lk_dout", dout, line);
        if (phit || amode == 1) return;

        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) begin
            @(negedge clk); clr(); #1;
            chk("mr_req", mem_req, 1);
            chk("mr_addr", mem_addr, {a[31:4], 4'h0});
        end
        @(negedge clk); clr();
        if (amode == 2) abort = 1;
        else begin mem_gnt = 1; abort = (amode == 4); end
        #1;
        chk("mr_req", mem_req, 1);
        chk("mr_addr", mem_addr, {a[31:4], 4'h0});
        chk("mr_dv", dout_valid, 0);
        if (amode == 2) return;

        for (int b = 0; b < 4; b++) begin
            w = $urandom_range(0, 2);
            for (int i = 0; i < w; i++) begin
                @(negedge clk); clr(); #1;
                chk("rf_dv", dout_valid, 0);
                chk("rf_req", mem_req, 0);
            end
            @(negedge clk); clr(); mem_rvalid = 1; mem_rdata = memw(a, b);
            abort = (amode == 3 && b == k); inv = (do_inv && b == k); #1;
            chk("rf_dv", dout_valid, 0);
        end

        @(negedge clk); clr(); abort = (amode == 5); #1;
        pdv = !(amode == 3 || amode == 4 || amode == 5);
        chk("fl_we", data_we, 1);
        chk("fl_idx", data_idx, ix);
        chk("fl_wdata", data_wdata, line);
        chk("fl_dv", dout_valid, pdv);
        if (pdv) chk("fl_dout", dout, line);
        mtag[ix] = tg; mvalid[ix] = 1;
        if (do_inv) model_inv();
    endtask

    initial begin
        vec_t        tbl[14];
        logic [127:0] l1;
        logic [31:0] ba[4];
        logic [31:0] a;
        bit          h;
        int          r, am;

        l1 = 128'h44444444_33333333_22222222_11111111;
        tbl[0]  = mkv(0, 32'h0,  0, 0, 32'h0,        1, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[1]  = mkv(1, 32'h40, 0, 0, 32'h0,        1, 0, 0, 32'h0,  0, 1, 4, '0);
        tbl[2]  = mkv(0, 32'h40, 0, 0, 32'h0,        0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[3]  = mkv(0, 32'h40, 0, 0, 32'h0,        0, 0, 1, 32'h40, 0, 0, 0, '0);
        tbl[4]  = mkv(0, 32'h40, 1, 0, 32'h0,        0, 0, 1, 32'h40, 0, 0, 0, '0);
        tbl[5]  = mkv(0, 32'h40, 0, 1, 32'h11111111, 0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[6]  = mkv(0, 32'h40, 0, 1, 32'h22222222, 0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[7]  = mkv(0, 32'h40, 0, 0, 32'h0,        0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[8]  = mkv(0, 32'h40, 0, 1, 32'h33333333, 0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[9]  = mkv(0, 32'h40, 0, 1, 32'h44444444, 0, 0, 0, 32'h0,  0, 0, 0, '0);
        tbl[10] = mkv(0, 32'h40, 0, 0, 32'h0,        0, 1, 0, 32'h0,  1, 0, 4, l1);
        tbl[11] = mkv(1, 32'h48, 0, 0, 32'h0,        1, 0, 0, 32'h0,  0, 1, 4, '0);
        tbl[12] = mkv(0, 32'h48, 0, 0, 32'h0,        1, 1, 0, 32'h0,  0, 0, 0, l1);
        tbl[13] = mkv(0, 32'h48, 0, 0, 32'h0,        1, 0, 0, 32'h0,  0, 0, 0, '0);

        for (int i = 0; i < LINES; i++) darr[i] = '0;
        model_inv();

        rst_n = 0; clr(); pc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_dv", dout_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", data_we, 0);
        chk("rst_rden", data_rd_en, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk); clr();
            rd_en = tbl[i].rd; pc = tbl[i].pc; mem_gnt = tbl[i].gnt;
            mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdat;
            #1;
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_dv", i), dout_valid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_we", i), data_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_rden", i), data_rd_en, tbl[i].e_rden);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_dv) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), data_wdata, tbl[i].e_dout);
            if (tbl[i].e_we || tbl[i].e_rden) chk($sformatf("tbl%0d_idx", i), data_idx, tbl[i].e_idx);
        end

        // invalidate in IDLE, then the table's line must miss
        @(negedge clk); clr(); inv = 1; #1;
        chk("inv_idle_ready", ready, 1);
        model_inv();
        txn(32'h40, 0, 0, 0, h);
        chk("after_inv_miss", h, 0);

        // back-to-back hits
        ba[0] = 32'h100; ba[1] = 32'h110; ba[2] = 32'h120; ba[3] = 32'h130;
        for (int i = 0; i < 4; i++) txn(ba[i], 0, 0, 0, h);
        @(negedge clk); clr(); rd_en = 1; pc = ba[0]; #1;
        chk("b2b_ready0", ready, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); clr(); rd_en = 1; pc = ba[i]; #1;
            chk("b2b_ready", ready, 1);
            chk("b2b_dv", dout_valid, 1);
            chk("b2b_dout", dout, line_of(ba[i-1]));
        end
        @(negedge clk); clr(); #1;
        chk("b2b_dv_last", dout_valid, 1);
        chk("b2b_dout_last", dout, line_of(ba[3]));
        @(negedge clk); clr(); #1;
        chk("b2b_dv_end", dout_valid, 0);

        // abort after the second beat: line still written, later hit
        txn(32'h200, 3, 1, 0, h);
        txn(32'h208, 0, 0, 0, h);
        chk("abort_then_hit", h, 1);

        // conflict eviction
        txn(32'h40, 0, 0, 0, h);
        txn(32'h40 + LINES * 16, 0, 0, 0, h);
        chk("conflict_second_miss", h, 0);
        txn(32'h40, 0, 0, 0, h);
        chk("conflict_first_remiss", h, 0);

        // invalidate during refill
        txn(32'h300, 0, 2, 1, h);
        txn(32'h300, 0, 0, 0, h);
        chk("inv_refill_miss_self", h, 0);
        txn(32'h110, 0, 0, 0, h);
        chk("inv_refill_miss_other", h, 0);

        // reset in the middle of a refill, stray beats afterwards
        txn(32'h600, 0, 0, 0, h);
        @(negedge clk); clr(); rd_en = 1; pc = 32'h500;
        @(negedge clk); clr();
        @(negedge clk); clr(); mem_gnt = 1;
        @(negedge clk); clr(); mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); clr(); rst_n = 0; #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_req", mem_req, 0);
        chk("midrst_dv", dout_valid, 0);
        model_inv();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr(); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0_0000; #1;
            chk("stray_dv", dout_valid, 0);
            chk("stray_ready", ready, 1);
            chk("stray_we", data_we, 0);
        end
        txn(32'h600, 0, 0, 0, h);
        chk("rst_clears_valid", h, 0);

        // randomized transactions
        for (int t = 0; t < 200; t++) begin
            a = (32'($urandom_range(0, 2)) * LINES * 16) + (32'($urandom_range(0, 7)) << 4)
                + 32'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            am = (r < 5) ? 0 : r - 4;
            txn(a, am, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), h);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); clr(); inv = 1; #1;
                chk("rnd_inv_ready", ready, 1);
                model_inv();
            end
        end

        @(negedge clk); clr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
